// File: rtl/wall_pkg.sv
// Shared types and constants for the wall spawner.
// Holds the FSM state encoding, the default screen/grid geometry with its
// derived cell counts, and the default 16-bit Galois tap polynomial.
package wall_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DRAW_X,
    ST_DRAW_Y,
    ST_CHECK,
    ST_WRITE,
    ST_IDLE
  } wall_state_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_GRID     = 16;

  localparam int CELLS_X = DEF_SCREEN_W / DEF_GRID;
  localparam int CELLS_Y = DEF_SCREEN_H / DEF_GRID;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // Number of LFSR bits needed to address every grid cell along one axis.
  function automatic int cell_bits(input int extent, input int grid);
    return $clog2(extent / grid);
  endfunction

  localparam int CELL_W = cell_bits(DEF_SCREEN_W, DEF_GRID);

endpackage

// File: rtl/wall_lfsr.sv
// Free-running Galois LFSR shared by all wall slots.
// Shifts right every cycle and XORs the tap mask in when the bit shifted
// out is one. Only the low OUT_W bits are exported.
module wall_lfsr #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0]   TAPS  = 16'hB400,
  parameter int                 OUT_W = 6
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  output logic [OUT_W-1:0] value
);

  logic [WIDTH-1:0] state_q;

  // Advance one step per clock; never stalls.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/wall_spawner.sv
// Wall spawner: fills NUM_WALLS slots with grid-aligned random positions
// that avoid a player keep-out square, and re-places single slots on request.
// Optional feature macro: WALL_SPAWN_DUP_CHECK_EN also rejects a candidate
// that lands on another valid wall.
// Range rejections found while drawing are deferred to CHECK, so every
// rejected draw costs exactly one DRAW_X/DRAW_Y/CHECK round trip.
module wall_spawner
  import wall_pkg::*;
#(
  parameter int                NUM_WALLS = 4,
  parameter int                COORD_W   = 11,
  parameter int                SCREEN_W  = 640,
  parameter int                SCREEN_H  = 480,
  parameter int                GRID      = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 15
) (
  input  logic                         pixel_clk,
  input  logic                         reset_n,
  input  logic                         respawn_req,
  input  logic [3:0]                   respawn_idx,
  output logic                         respawn_ack,
  input  logic [COORD_W-1:0]           keepout_x,
  input  logic [COORD_W-1:0]           keepout_y,
  input  logic [COORD_W-1:0]           keepout_sz,
  output logic [NUM_WALLS*COORD_W-1:0] wall_x,
  output logic [NUM_WALLS*COORD_W-1:0] wall_y,
  output logic [NUM_WALLS-1:0]         wall_valid,
  output logic                         all_placed,
  output logic                         place_fail
);

  localparam int NCELL_X = SCREEN_W / GRID;
  localparam int NCELL_Y = SCREEN_H / GRID;
  localparam int CW      = cell_bits(SCREEN_W, GRID);
  localparam int GRID_SH = $clog2(GRID);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [CW:0]        NCELL_X_V = (CW+1)'(NCELL_X);
  localparam logic [CW:0]        NCELL_Y_V = (CW+1)'(NCELL_Y);
  localparam logic [4:0]         NUM_V     = 5'(NUM_WALLS);
  localparam logic [3:0]         LAST_SLOT = 4'(NUM_WALLS - 1);
  localparam logic [TRY_W-1:0]   LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [COORD_W:0]   GRID_V    = (COORD_W+1)'(GRID);
  localparam logic [LFSR_W-1:0]  TAPS      = LFSR_W'(LFSR_TAPS_16);

  wall_state_e        state_q, state_d;
  logic [3:0]         slot_q;
  logic [TRY_W-1:0]   tries_q;
  logic [CW-1:0]      cand_x_q, cand_y_q;
  logic               x_bad_q, y_bad_q, give_up_q, ack_inv_q;
  logic [CW-1:0]      draw;
  logic [COORD_W-1:0] cand_px, cand_py;
  logic [COORD_W:0]   ko_x_end, ko_y_end, cell_x_end, cell_y_end;
  logic               in_keepout, dup_hit, reject, last_try, idx_ok, req_seen;

  wall_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED),
    .TAPS  (TAPS),
    .OUT_W (CW)
  ) u_lfsr (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .value     (draw)
  );

  assign cand_px = COORD_W'(cand_x_q) << GRID_SH;
  assign cand_py = COORD_W'(cand_y_q) << GRID_SH;

  // Keep-out overlap test, one bit wider so the square's far edge never wraps.
  always_comb begin
    ko_x_end   = {1'b0, keepout_x} + {1'b0, keepout_sz};
    ko_y_end   = {1'b0, keepout_y} + {1'b0, keepout_sz};
    cell_x_end = {1'b0, cand_px} + GRID_V;
    cell_y_end = {1'b0, cand_py} + GRID_V;
    in_keepout = (keepout_sz != '0)
              && ({1'b0, cand_px} < ko_x_end) && ({1'b0, keepout_x} < cell_x_end)
              && ({1'b0, cand_py} < ko_y_end) && ({1'b0, keepout_y} < cell_y_end);
  end

`ifdef WALL_SPAWN_DUP_CHECK_EN
  // Flag a candidate that sits exactly on another slot's valid wall.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (wall_valid[i] && (4'(i) != slot_q)
          && (wall_x[i*COORD_W +: COORD_W] == cand_px)
          && (wall_y[i*COORD_W +: COORD_W] == cand_py)) begin
        dup_hit = 1'b1;
      end
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  assign reject   = x_bad_q || y_bad_q || in_keepout || dup_hit;
  assign last_try = (tries_q == LAST_TRY);
  assign idx_ok   = ({1'b0, respawn_idx} < NUM_V);
  assign req_seen = respawn_req && !ack_inv_q;

  // State register.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; invalid-index requests are answered without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_DRAW_X;
      ST_DRAW_X: state_d = ST_DRAW_Y;
      ST_DRAW_Y: state_d = ST_CHECK;
      ST_CHECK:  state_d = (reject && !last_try) ? ST_DRAW_X : ST_WRITE;
      ST_WRITE:  state_d = (all_placed || slot_q == LAST_SLOT) ? ST_IDLE : ST_DRAW_X;
      ST_IDLE:   if (req_seen && idx_ok) state_d = ST_DRAW_X;
      default:   state_d = ST_INIT;
    endcase
  end

  // Candidate capture, try counting, slot bookkeeping and wall table updates.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q     <= '0;
      tries_q    <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      x_bad_q    <= 1'b0;
      y_bad_q    <= 1'b0;
      give_up_q  <= 1'b0;
      ack_inv_q  <= 1'b0;
      wall_x     <= '0;
      wall_y     <= '0;
      wall_valid <= '0;
      all_placed <= 1'b0;
      place_fail <= 1'b0;
    end else begin
      ack_inv_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          slot_q    <= '0;
          tries_q   <= '0;
          give_up_q <= 1'b0;
        end
        ST_DRAW_X: begin
          cand_x_q <= draw;
          x_bad_q  <= ({1'b0, draw} >= NCELL_X_V);
        end
        ST_DRAW_Y: begin
          cand_y_q <= draw;
          y_bad_q  <= ({1'b0, draw} >= NCELL_Y_V);
        end
        ST_CHECK: begin
          if (reject) begin
            if (last_try) begin
              give_up_q <= 1'b1;
            end else begin
              tries_q <= tries_q + TRY_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (give_up_q) begin
            place_fail <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_WALLS; i++) begin
              if (4'(i) == slot_q) begin
                wall_x[i*COORD_W +: COORD_W] <= cand_px;
                wall_y[i*COORD_W +: COORD_W] <= cand_py;
                wall_valid[i]                <= 1'b1;
              end
            end
          end
          tries_q   <= '0;
          give_up_q <= 1'b0;
          if (!all_placed) begin
            if (slot_q == LAST_SLOT) begin
              all_placed <= 1'b1;
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
        end
        ST_IDLE: begin
          if (req_seen) begin
            if (idx_ok) begin
              slot_q  <= respawn_idx;
              tries_q <= '0;
              for (int i = 0; i < NUM_WALLS; i++) begin
                if (4'(i) == respawn_idx) wall_valid[i] <= 1'b0;
              end
            end else begin
              ack_inv_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign respawn_ack = ack_inv_q || ((state_q == ST_WRITE) && all_placed);

endmodule

// File: tb/tb_wall_spawner.sv
// Directed testbench for wall_spawner: reset values, initial fill,
// respawn handshake timing, invalid index, try-limit abandon,
// asynchronous reset and a request held across the initial fill.
module tb_wall_spawner;

  localparam int NW = 4;
  localparam int CW = 11;

  logic              pixel_clk = 1'b0;
  logic              reset_n   = 1'b0;
  logic              respawn_req = 1'b0;
  logic [3:0]        respawn_idx = 4'd0;
  logic              respawn_ack;
  logic [CW-1:0]     keepout_x  = '0;
  logic [CW-1:0]     keepout_y  = '0;
  logic [CW-1:0]     keepout_sz = '0;
  logic [NW*CW-1:0]  wall_x, wall_y;
  logic [NW-1:0]     wall_valid;
  logic              all_placed, place_fail;

  int n_checks = 0;
  int n_fail   = 0;

  wall_spawner dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .respawn_req (respawn_req),
    .respawn_idx (respawn_idx),
    .respawn_ack (respawn_ack),
    .keepout_x   (keepout_x),
    .keepout_y   (keepout_y),
    .keepout_sz  (keepout_sz),
    .wall_x      (wall_x),
    .wall_y      (wall_y),
    .wall_valid  (wall_valid),
    .all_placed  (all_placed),
    .place_fail  (place_fail)
  );

  // 100 MHz pixel clock.
  always #5 pixel_clk = ~pixel_clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    #12;
    n_checks++; if (wall_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0h want 0", wall_valid); end
    n_checks++; if (wall_x !== '0 || wall_y !== '0) begin n_fail++; $display("[TB] FAIL reset_xy: got x=%0h y=%0h want 0", wall_x, wall_y); end
    n_checks++; if (all_placed !== 1'b0 || place_fail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got placed=%b fail=%b want 0 0", all_placed, place_fail); end
    n_checks++; if (respawn_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b want 0", respawn_ack); end
  endtask

  task automatic test_initial_fill();
    logic          saw_ack;
    logic          ok;
    logic [CW-1:0] wx, wy;
    saw_ack = 1'b0;
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge pixel_clk);
      if (respawn_ack === 1'b1) saw_ack = 1'b1;
      if (all_placed === 1'b1) break;
    end
    n_checks++; if (all_placed !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_done: got %b want 1 within 400 cycles", all_placed); end
    n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_no_ack: got %b want 0", saw_ack); end
    n_checks++; if (wall_valid !== 4'hF) begin n_fail++; $display("[TB] FAIL fill_valid: got %0h want f", wall_valid); end
    n_checks++; if (place_fail !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_place_fail: got %b want 0", place_fail); end
    for (int i = 0; i < NW; i++) begin
      wx = wall_x[i*CW +: CW];
      wy = wall_y[i*CW +: CW];
      ok = (wx[3:0] == 4'd0) && (wx < 11'd640);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_x slot %0d: got %0d want multiple of 16 below 640", i, wx); end
      ok = (wy[3:0] == 4'd0) && (wy < 11'd480);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_y slot %0d: got %0d want multiple of 16 below 480", i, wy); end
    end
`ifdef WALL_SPAWN_DUP_CHECK_EN
    ok = 1'b1;
    for (int i = 0; i < NW; i++)
      for (int j = i + 1; j < NW; j++)
        if (wall_x[i*CW +: CW] == wall_x[j*CW +: CW] && wall_y[i*CW +: CW] == wall_y[j*CW +: CW]) ok = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL dup_free: got shared cell want all distinct"); end
`endif
  endtask

  task automatic test_respawn();
    logic [NW*CW-1:0] old_x, old_y, keep;
    logic             low_ok, ok;
    int               lat;
    logic [CW-1:0]    wx, wy;
    old_x  = wall_x;
    old_y  = wall_y;
    keep   = ~({{(NW*CW-CW){1'b0}}, {CW{1'b1}}} << (2*CW));
    low_ok = 1'b1;
    lat    = 0;
    @(negedge pixel_clk);
    respawn_idx = 4'd2;
    respawn_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge pixel_clk);
      if (wall_valid[2] !== 1'b0) low_ok = 1'b0;
      if (respawn_ack === 1'b1) begin
        lat = k;
        respawn_req = 1'b0;
        break;
      end
    end
    respawn_req = 1'b0;
    ok = (lat >= 4) && ((lat - 4) % 3 == 0);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL respawn_latency: got %0d want 4+3n", lat); end
    n_checks++; if (low_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL respawn_valid_low: slot 2 valid seen high before write"); end
    @(negedge pixel_clk);
    n_checks++; if (respawn_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL respawn_pulse: got %b want 0", respawn_ack); end
    n_checks++; if (wall_valid !== 4'hF) begin n_fail++; $display("[TB] FAIL respawn_valid: got %0h want f", wall_valid); end
    n_checks++; if ((wall_x & keep) !== (old_x & keep) || (wall_y & keep) !== (old_y & keep)) begin
      n_fail++; $display("[TB] FAIL respawn_others: got x=%0h y=%0h want x=%0h y=%0h outside slot 2", wall_x & keep, wall_y & keep, old_x & keep, old_y & keep);
    end
    wx = wall_x[2*CW +: CW];
    wy = wall_y[2*CW +: CW];
    ok = (wx[3:0] == 4'd0) && (wx < 11'd640) && (wy[3:0] == 4'd0) && (wy < 11'd480);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL respawn_coord: got (%0d,%0d) want grid-aligned on screen", wx, wy); end
  endtask

  task automatic test_invalid_idx();
    logic [NW*CW-1:0] old_x, old_y;
    logic [NW-1:0]    old_v;
    old_x = wall_x;
    old_y = wall_y;
    old_v = wall_valid;
    @(negedge pixel_clk);
    respawn_idx = 4'd9;
    respawn_req = 1'b1;
    @(negedge pixel_clk);
    n_checks++; if (respawn_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL invalid_ack: got %b want 1 at T+1", respawn_ack); end
    respawn_req = 1'b0;
    @(negedge pixel_clk);
    n_checks++; if (respawn_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid_pulse: got %b want 0", respawn_ack); end
    n_checks++; if (wall_x !== old_x || wall_y !== old_y || wall_valid !== old_v) begin
      n_fail++; $display("[TB] FAIL invalid_nochange: got v=%0h want v=%0h (coords compared too)", wall_valid, old_v);
    end
  endtask

  task automatic test_keepout_fail();
    int lat;
    lat = 0;
    @(negedge pixel_clk);
    keepout_x   = 11'd0;
    keepout_y   = 11'd0;
    keepout_sz  = 11'd640;
    respawn_idx = 4'd1;
    respawn_req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge pixel_clk);
      if (respawn_ack === 1'b1) begin
        lat = k;
        respawn_req = 1'b0;
        break;
      end
    end
    respawn_req = 1'b0;
    n_checks++; if (lat !== 46) begin n_fail++; $display("[TB] FAIL keepout_latency: got %0d want 46", lat); end
    @(negedge pixel_clk);
    n_checks++; if (place_fail !== 1'b1) begin n_fail++; $display("[TB] FAIL keepout_place_fail: got %b want 1", place_fail); end
    n_checks++; if (wall_valid !== 4'b1101) begin n_fail++; $display("[TB] FAIL keepout_valid: got %b want 1101", wall_valid); end
    keepout_sz = 11'd0;
  endtask

  task automatic test_async_reset();
    @(negedge pixel_clk);
    respawn_idx = 4'd0;
    respawn_req = 1'b1;
    @(negedge pixel_clk);
    @(posedge pixel_clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (wall_valid !== 4'h0 || wall_x !== '0 || wall_y !== '0) begin
      n_fail++; $display("[TB] FAIL async_walls: got v=%0h x=%0h y=%0h want 0", wall_valid, wall_x, wall_y);
    end
    n_checks++; if (all_placed !== 1'b0 || place_fail !== 1'b0 || respawn_ack !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_flags: got placed=%b fail=%b ack=%b want 0 0 0", all_placed, place_fail, respawn_ack);
    end
    respawn_req = 1'b0;
  endtask

  task automatic test_pending_during_fill();
    logic early;
    int   lat;
    early = 1'b0;
    lat   = 0;
    respawn_idx = 4'd3;
    respawn_req = 1'b1;
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge pixel_clk);
      if (respawn_ack === 1'b1) begin
        if (all_placed !== 1'b1) begin
          early = 1'b1;
        end else begin
          lat = k;
          respawn_req = 1'b0;
          break;
        end
      end
    end
    respawn_req = 1'b0;
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("[TB] FAIL pending_early_ack: got %b want 0", early); end
    n_checks++; if (lat == 0) begin n_fail++; $display("[TB] FAIL pending_served: got no ack want ack after fill"); end
    @(negedge pixel_clk);
    n_checks++; if (wall_valid !== 4'hF || place_fail !== 1'b0) begin
      n_fail++; $display("[TB] FAIL pending_final: got v=%0h fail=%b want f 0", wall_valid, place_fail);
    end
  endtask

  initial begin
    $display("[TB] wall_spawner directed test start");
    test_reset();
    test_initial_fill();
    test_respawn();
    test_invalid_idx();
    test_keepout_fail();
    test_async_reset();
    test_pending_during_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wall_spawner.md
Name: wall_spawner

Overview:
Successor to the single-wall placer. Owns NUM_WALLS wall slots and fills each with a grid-aligned, on-screen, pseudo-random (x,y) from one shared free-running LFSR. Rejects candidates that fall inside a player keep-out square. Supports per-slot respawn through a req/ack handshake. Sits between the game-state logic and the pixel renderer, in the pixel_clk domain.

Parameters:
NUM_WALLS, 4, number of wall slots (1..16)
COORD_W, 11, coordinate width in bits
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
GRID, 16, placement grid pitch in pixels (power of two)
LFSR_W, 16, LFSR width
SEED, 16'hACE1, LFSR reset value (must be non-zero)
MAX_TRIES, 15, rejected draws allowed before a slot is abandoned

Ports:
pixel_clk  in  1  pixel clock, single clock domain
reset_n  in  1  asynchronous active-low reset
respawn_req  in  1  request to re-place slot respawn_idx; held until ack
respawn_idx  in  4  slot index for the request
respawn_ack  out  1  one-cycle pulse when the request completes
keepout_x  in  COORD_W  keep-out square, top-left x
keepout_y  in  COORD_W  keep-out square, top-left y
keepout_sz  in  COORD_W  keep-out square side length
wall_x  out  NUM_WALLS*COORD_W  flattened slot x coordinates; slot i at [i*COORD_W +: COORD_W]
wall_y  out  NUM_WALLS*COORD_W  flattened slot y coordinates
wall_valid  out  NUM_WALLS  slot holds a placed wall
all_placed  out  1  initial fill finished
place_fail  out  1  sticky: some slot exceeded MAX_TRIES

Behaviour:
- Reset (async, reset_n low): LFSR=SEED; wall_x=wall_y=0; wall_valid=0; respawn_ack=0; all_placed=0; place_fail=0; FSM=INIT; slot pointer=0.
- LFSR: Galois, advances every pixel_clk cycle, never stalls.
- Candidate cells: cx = LFSR low bits masked to clog2(SCREEN_W/GRID) bits; cy uses the same masking on the LFSR value sampled one cycle later.
- Coordinate: x = cx*GRID, y = cy*GRID.
- FSM states:
  - INIT: load the slot pointer, go to DRAW_X.
  - DRAW_X: capture cx. Reject if cx >= SCREEN_W/GRID.
  - DRAW_Y: capture cy. Reject if cy >= SCREEN_H/GRID.
  - CHECK: reject if the wall cell overlaps the square [keepout_x, keepout_x+keepout_sz) x [keepout_y, keepout_y+keepout_sz), both axes.
  - WRITE: update wall_x/wall_y, set wall_valid[slot]=1.
  - IDLE: wait for requests.
- Rejections: any rejection increments the try counter and returns to DRAW_X. Try counter resets to 0 on each new slot.
- Try limit reached: set place_fail, leave wall_valid[slot]=0, proceed as if written.
- Initial fill: slots 0..NUM_WALLS-1 in order. After the last WRITE: all_placed=1, FSM=IDLE.
- Requests during initial fill are not accepted; they stay pending.
- Respawn: sampled only in IDLE. Accept at cycle T:
  - wall_valid[idx] is cleared at T+1.
  - Zero rejections: DRAW_X T+1, DRAW_Y T+2, CHECK T+3, WRITE and respawn_ack=1 at T+4.
  - Each rejection adds 3 cycles.
- Invalid index (respawn_idx >= NUM_WALLS): respawn_ack at T+1, no state change.
- After ack, FSM returns to IDLE for at least one cycle before another request is accepted. Requester must drop req in the ack cycle.
- keepout_* are sampled in CHECK and are not registered at accept; they may change mid-operation.
- Unused LFSR bits are ignored. Arithmetic is unsigned, COORD_W+1 bits for the keep-out upper bound (no wrap).

Optional Feature:
WALL_SPAWN_DUP_CHECK_EN:
- Defined: CHECK also rejects a candidate equal in (x,y) to any other slot with wall_valid=1 (excluding the slot being placed). Counts toward MAX_TRIES.
- Undefined: duplicates allowed; comparator logic absent.

Decomposition:
- wall_pkg: FSM state enum (INIT, DRAW_X, DRAW_Y, CHECK, WRITE, IDLE); derived constants CELLS_X=SCREEN_W/GRID, CELLS_Y=SCREEN_H/GRID, mask widths; default LFSR tap polynomial for 16 bits (0xB400).
- Sub-module wall_lfsr: parametrised width, seed and taps; async active-low reset; free-running.

Test Plan:
1. Release reset, keepout_sz=0: all_placed=1 within 4*4 + reject slack cycles; every wall_x multiple of 16 and <640; every wall_y multiple of 16 and <480; wall_valid=4'b1111; place_fail=0.
2. Initial fill done, respawn_req=1, idx=2: respawn_ack is a single pulse; only slot 2 coordinates change; wall_valid[2] low from T+1 until WRITE; zero-rejection path acks exactly at T+4.
3. keepout (0,0) size 640, then respawn idx=1: after MAX_TRIES rejections, place_fail=1, wall_valid[1]=0, ack still pulses.
4. respawn_idx=9 in IDLE: ack at T+1; wall_x, wall_y and wall_valid unchanged.
5. respawn_req asserted during initial fill: no ack until after all_placed=1; request is then served.
6. Drop reset_n mid-DRAW_Y of a respawn: outputs return to reset values immediately (asynchronously). With WALL_SPAWN_DUP_CHECK_EN defined and a forced-equal candidate, the candidate is rejected and no two valid slots share (x,y).
